// File: rtl/oven_timer_pkg.sv
// rtl/oven_timer_pkg.sv - shared state encoding, BCD limits and countdown helper for the oven timer
package oven_timer_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Largest legal BCD digit, and the seconds-tens value reloaded on a minute borrow
  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

  // Four displayed digits, most significant first (MM:SS)
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // One-second BCD decrement; caller guarantees the time is not 00:00.
  // Seconds may hold 60-99 as keyed, so only the all-zero seconds case borrows.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else if (t.sec_tens != 4'd0) begin
      r.sec_ones = BCD_MAX;
      r.sec_tens = t.sec_tens - 4'd1;
    end else begin
      r.sec_ones = BCD_MAX;
      r.sec_tens = SEC_TENS_WRAP;
      if (t.min_ones != 4'd0) begin
        r.min_ones = t.min_ones - 4'd1;
      end else begin
        r.min_ones = BCD_MAX;
        r.min_tens = t.min_tens - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - two-flop synchronizer plus registered single-cycle rising-edge pulse
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic sync1_d, sync2_d, prev_d, pulse_d;

  // Synchronizer chain and edge detect; a held button only ever yields one pulse
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  // Button pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/oven_countdown_timer.sv
// rtl/oven_countdown_timer.sv - MM:SS BCD keyed countdown timer with done hold-off
module oven_countdown_timer
  import oven_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DONE_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  input  logic       enter,
  input  logic       start,
  input  logic       cancel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DCNT_W = (DONE_SECS > 1) ? $clog2(DONE_SECS + 1) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DONE_SECS - 1);

  logic enter_p, start_p, cancel_p;

  button_edge u_enter  (.clk(clk), .rst(rst), .btn(enter),  .pulse(enter_p));
  button_edge u_start  (.clk(clk), .rst(rst), .btn(start),  .pulse(start_p));
  button_edge u_cancel (.clk(clk), .rst(rst), .btn(cancel), .pulse(cancel_p));

  logic [1:0]        state_q, state_d;
  bcd_time_t         digits_q, digits_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              tick;

  assign tick = (pre_q == PRE_LAST);

  // Next-state: cancel beats start beats enter beats the one-second tick
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    dcnt_d   = dcnt_q;
    pre_d    = tick ? '0 : pre_q + 1'b1;
    if (cancel_p) begin
      state_d  = ST_IDLE;
      digits_d = '0;
    end else if (start_p && (state_q == ST_ENTRY) && (digits_q != '0)) begin
      // Restart the prescaler so the first decrement is a full second away
      state_d = ST_RUN;
      pre_d   = '0;
    end else if (enter_p && ((state_q == ST_IDLE) || (state_q == ST_ENTRY)) && (in <= BCD_MAX)) begin
      state_d  = ST_ENTRY;
      digits_d = {digits_q.min_ones, digits_q.sec_tens, digits_q.sec_ones, in};
    end else if (tick && (state_q == ST_RUN)) begin
      digits_d = bcd_dec(digits_q);
      if (digits_d == '0) begin
        state_d = ST_DONE;
        pre_d   = '0;
        dcnt_d  = '0;
      end
    end else if (tick && (state_q == ST_DONE)) begin
      if (dcnt_q == DCNT_LAST) begin
        state_d = ST_IDLE;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, digits, prescaler, done counter and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      digits_q  <= '0;
      pre_q     <= '0;
      dcnt_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      pre_q     <= pre_d;
      dcnt_q    <= dcnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign min_tens = digits_q.min_tens;
  assign min_ones = digits_q.min_ones;
  assign sec_tens = digits_q.sec_tens;
  assign sec_ones = digits_q.sec_ones;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_oven_countdown_timer.sv
// tb/tb_oven_countdown_timer.sv - randomized and directed bench for oven_countdown_timer against a decimal model
module tb_oven_countdown_timer;

  localparam int TICK_DIV  = 4;
  localparam int DONE_SECS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_dig = 4'd0;
  logic       enter = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done;
  logic [15:0] dut_digits;

  int n_tests = 0;
  int n_fail  = 0;

  oven_countdown_timer #(.TICK_DIV(TICK_DIV), .DONE_SECS(DONE_SECS)) dut (
    .clk(clk), .rst(rst), .in(in_dig), .enter(enter), .start(start), .cancel(cancel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done)
  );

  assign dut_digits = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time kept as one decimal number MMSS (0..9999)
  int m_val   = 0;
  int m_state = M_IDLE;
  int m_since = 0;
  int m_dsecs = 0;
  logic [3:0] h_enter = '0, h_start = '0, h_cancel = '0;

  function automatic logic [15:0] model_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // A raw level sampled high at edge e-3 after low at e-4 acts at edge e
  always @(posedge clk or posedge rst) begin
    bit pe, ps, pc, tk;
    if (rst) begin
      m_val = 0; m_state = M_IDLE; m_since = 0; m_dsecs = 0;
      h_enter = '0; h_start = '0; h_cancel = '0;
    end else begin
      pe = h_enter[2] & ~h_enter[3];
      ps = h_start[2] & ~h_start[3];
      pc = h_cancel[2] & ~h_cancel[3];
      h_enter  = {h_enter[2:0], enter};
      h_start  = {h_start[2:0], start};
      h_cancel = {h_cancel[2:0], cancel};
      m_since++;
      tk = (m_since % TICK_DIV) == 0;
      if (pc) begin
        m_state = M_IDLE; m_val = 0;
      end else if (ps && m_state == M_ENTRY && m_val != 0) begin
        m_state = M_RUN; m_since = 0;
      end else if (pe && (m_state == M_IDLE || m_state == M_ENTRY) && in_dig <= 4'd9) begin
        m_state = M_ENTRY; m_val = (m_val * 10 + int'(in_dig)) % 10000;
      end else if (tk && m_state == M_RUN) begin
        if (m_val % 100 != 0) m_val = m_val - 1;
        else m_val = m_val - 100 + 59;
        if (m_val == 0) begin m_state = M_DONE; m_dsecs = 0; end
      end else if (tk && m_state == M_DONE) begin
        m_dsecs++;
        if (m_dsecs == DONE_SECS) m_state = M_IDLE;
      end
    end
  end

  // Every cycle, the DUT outputs must match the model
  always @(negedge clk) begin
    if (!rst)
      check("cyc", {14'd0, dut_digits, running, done},
            {14'd0, model_bcd(m_val), m_state == M_RUN, m_state == M_DONE});
  end

  task automatic drive_btn(input int which, input logic v);
    case (which)
      0: enter = v;
      1: start = v;
      default: cancel = v;
    endcase
  endtask

  // Called at a negedge; returns at the negedge where the button is released
  task automatic press(input int which, input int hold);
    drive_btn(which, 1'b1);
    repeat (hold) @(negedge clk);
    drive_btn(which, 1'b0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_digit(input int d);
    in_dig = 4'(d);
    press(0, 1);
    wait_cyc(4);
  endtask

  task automatic clear_all();
    press(2, 1);
    wait_cyc(4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, w;
    wait_cyc(3);
    check("rst_digits", dut_digits, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    wait_cyc(2);

    // Entry shift, then an invalid digit
    key_digit(1); key_digit(3); key_digit(0); key_digit(5);
    check("entry_1305", dut_digits, 16'h1305);
    key_digit(12);
    check("entry_invalid", dut_digits, 16'h1305);

    // Cancel latency: unchanged after k+2, cleared after k+3
    press(2, 1);
    wait_cyc(2);
    check("cancel_k2", dut_digits, 16'h1305);
    wait_cyc(1);
    check("cancel_k3", dut_digits, 16'h0000);
    wait_cyc(2);

    // Short countdown 00:03
    key_digit(0); key_digit(0); key_digit(0); key_digit(3);
    press(1, 1);
    wait_cyc(3);
    check("run_entry_running", running, 1'b1);
    check("run_entry_digits", dut_digits, 16'h0003);
    wait_cyc(3);
    check("pre_tick", dut_digits, 16'h0003);
    wait_cyc(1);
    check("tick1", dut_digits, 16'h0002);
    wait_cyc(4);
    check("tick2", dut_digits, 16'h0001);
    wait_cyc(4);
    check("tick3_digits", dut_digits, 16'h0000);
    check("tick3_done", done, 1'b1);
    check("tick3_running", running, 1'b0);
    wait_cyc(7);
    check("done_hold", done, 1'b1);
    wait_cyc(1);
    check("done_release", done, 1'b0);
    wait_cyc(2);

    // Minute borrow, and enter ignored during RUN
    key_digit(1); key_digit(0); key_digit(0);
    press(1, 1);
    wait_cyc(7);
    check("borrow_0059", dut_digits, 16'h0059);
    in_dig = 4'd4;
    press(0, 1);
    wait_cyc(3);
    check("enter_in_run", dut_digits, 16'h0058);
    clear_all();

    key_digit(9); key_digit(9); key_digit(1); key_digit(0);
    press(1, 1);
    wait_cyc(7);
    check("borrow_9909", dut_digits, 16'h9909);
    clear_all();

    // start with 0000 in IDLE and in ENTRY
    press(1, 1);
    wait_cyc(8);
    check("start_zero_idle", running, 1'b0);
    key_digit(0);
    press(1, 1);
    wait_cyc(8);
    check("start_zero_entry", running, 1'b0);
    clear_all();

    // Held enter shifts exactly once
    in_dig = 4'd7;
    press(0, 20);
    wait_cyc(4);
    check("held_enter", dut_digits, 16'h0007);

    // cancel and start together in ENTRY
    cancel = 1'b1; start = 1'b1;
    wait_cyc(1);
    cancel = 1'b0; start = 1'b0;
    wait_cyc(6);
    check("cancel_start_running", running, 1'b0);
    check("cancel_start_digits", dut_digits, 16'h0000);

    // Random sessions
    for (int it = 0; it < 30; it++) begin
      clear_all();
      nd = $urandom_range(1, 4);
      for (int j = 0; j < nd; j++) key_digit($urandom_range(0, 12));
      press(1, $urandom_range(1, 4));
      w = $urandom_range(0, 120);
      for (int c = 0; c < w; c++) begin
        case ($urandom_range(0, 15))
          0: begin in_dig = 4'($urandom_range(0, 15)); press(0, $urandom_range(1, 3)); end
          1: press(1, 1);
          default: wait_cyc(1);
        endcase
      end
      if ($urandom_range(0, 1) == 1) begin
        press(2, $urandom_range(1, 3));
      end
      wait_cyc(2);
    end

    // Asynchronous reset in the middle of RUN
    clear_all();
    key_digit(3); key_digit(0);
    press(1, 1);
    wait_cyc(10);
    check("pre_areset_running", running, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset_digits", dut_digits, 16'h0000);
    check("areset_running", running, 1'b0);
    check("areset_done", done, 1'b0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
